// File: rtl/icache_fetch_queue.sv
// Instruction-fetch front end: credit-limited icache requests, in-order {pc, instr} queue, redirect flush.
// Optional same-cycle response-to-decode bypass under `FETCH_QUEUE_BYPASS_EN.
module icache_fetch_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_2000,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  output logic                  icache_re,
  input  logic                  icache_req_ready,
  input  logic                  icache_resp_valid,
  input  logic [DATA_WIDTH-1:0] icache_dout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Back-to-back redirects can stack drops beyond DEPTH, so drop gets one extra bit of headroom.
  localparam int unsigned DW = CW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_if_pc [DEPTH];
  logic [AW-1:0]         r_if_rd, r_if_wr;
  logic [ADDR_WIDTH-1:0] r_q_pc [DEPTH];
  logic [DATA_WIDTH-1:0] r_q_instr [DEPTH];
  logic [AW-1:0]         r_q_rd, r_q_wr;
  logic [CW-1:0]         r_occ, r_out;
  logic [DW-1:0]         r_drop;

  logic w_credit, w_accept, w_resp, w_resp_live, w_resp_drop, w_resp_keep;
  logic w_q_empty, w_byp, w_push, w_pop;

  assign w_credit    = ({1'b0, r_occ} + {1'b0, r_out}) < LP_DEPTH;
  assign icache_re   = !reset && !redirect && w_credit;
  assign icache_addr = r_fetch_pc;
  assign w_accept    = icache_re && icache_req_ready;

  // Responses with nothing in flight are ignored entirely.
  assign w_resp      = icache_resp_valid && ((r_drop != '0) || (r_out != '0));
  assign w_resp_drop = w_resp && (r_drop != '0);
  assign w_resp_live = w_resp && (r_drop == '0);
  assign w_resp_keep = w_resp_live && !redirect;
  assign w_q_empty   = (r_occ == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp     = w_resp_keep && w_q_empty;
  assign out_pc    = w_q_empty ? r_if_pc[r_if_rd] : r_q_pc[r_q_rd];
  assign out_instr = w_q_empty ? icache_dout      : r_q_instr[r_q_rd];
`else
  assign w_byp     = 1'b0;
  assign out_pc    = r_q_pc[r_q_rd];
  assign out_instr = r_q_instr[r_q_rd];
`endif

  assign out_valid = (!w_q_empty || w_byp) && !redirect;
  assign w_pop     = out_valid && out_ready && !w_q_empty;
  assign w_push    = w_resp_keep && !(w_byp && out_ready);

  // Redirect empties the in-flight PC FIFO outright; stale responses are tracked by r_drop alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_if_rd    <= '0;
      r_if_wr    <= '0;
      r_q_rd     <= '0;
      r_q_wr     <= '0;
      r_occ      <= '0;
      r_out      <= '0;
      r_drop     <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_if_rd    <= '0;
      r_if_wr    <= '0;
      r_q_rd     <= '0;
      r_q_wr     <= '0;
      r_occ      <= '0;
      r_out      <= '0;
      r_drop     <= r_drop + DW'(r_out) - DW'(w_resp);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(PC_STEP);
        r_if_wr    <= r_if_wr + AW'(1);
      end
      if (w_resp_live) r_if_rd <= r_if_rd + AW'(1);
      if (w_push)      r_q_wr  <= r_q_wr + AW'(1);
      if (w_pop)       r_q_rd  <= r_q_rd + AW'(1);
      if (w_resp_drop) r_drop  <= r_drop - DW'(1);
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
      r_out <= r_out + CW'(w_accept) - CW'(w_resp_live);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_if_pc[r_if_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_q_wr]    <= r_if_pc[r_if_rd];
      r_q_instr[r_q_wr] <= icache_dout;
    end
  end
endmodule

// File: tb/tb_icache_fetch_queue.sv
// Randomized bench for icache_fetch_queue: in-order icache model plus a tagged in-flight/queue reference model.
module tb_icache_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_2000;
  localparam int unsigned PC_STEP  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic        icache_req_ready = 1'b0, icache_resp_valid = 1'b0;
  logic [31:0] icache_dout = '0;
  logic        out_valid;
  logic [31:0] out_instr, out_pc;
  logic        out_ready = 1'b0;

  icache_fetch_queue #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)
  ) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_req_ready(icache_req_ready),
    .icache_resp_valid(icache_resp_valid), .icache_dout(icache_dout),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } inf_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] data; int unsigned ready; } ic_t;

  inf_t m_inf[$];
  ent_t m_q[$];
  ic_t  ic[$];
  logic [31:0] m_pc = RESET_PC;
  bit   m_init = 0;
  int unsigned cyc = 0, lat_min = 1, lat_max = 1;
  bit   resp_always = 1;

  int unsigned vectors = 0, miscompares = 0;
  logic        g_ov, g_re;
  logic [31:0] g_pc, g_addr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit rr, input bit ordy);
    bit resp, exp_re, exp_ov, byp;
    int unsigned live;
    ent_t head;
    inf_t f;
    ic_t  d;
    @(negedge clk);
    reset = rst; redirect = redir; redirect_pc = redir ? rpc : $urandom();
    icache_req_ready = rr; out_ready = ordy;
    resp = !rst && (ic.size() > 0) && (ic[0].ready <= cyc) &&
           (resp_always || ($urandom_range(0, 3) != 0));
    icache_resp_valid = resp;
    icache_dout = resp ? ic[0].data : $urandom();
    live = 0;
    foreach (m_inf[i]) if (!m_inf[i].stale) live++;
    exp_re = !rst && !redir && ((m_q.size() + live) < DEPTH);
    byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = resp && (m_q.size() == 0) && (m_inf.size() > 0) && !m_inf[0].stale && !redir;
`endif
    exp_ov = ((m_q.size() > 0) || byp) && !redir;
    head = '{pc: '0, instr: '0};
    if (m_q.size() > 0) head = m_q[0];
    else if (byp) head = '{pc: m_inf[0].pc, instr: ic[0].data};
    #1;
    if (m_init) begin
      check("icache_re", {31'b0, icache_re}, {31'b0, exp_re});
      check("icache_addr", icache_addr, m_pc);
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      if (exp_ov) begin
        check("out_pc", out_pc, head.pc);
        check("out_instr", out_instr, head.instr);
      end
    end
    g_ov = out_valid; g_re = icache_re; g_pc = out_pc; g_addr = icache_addr;
    @(posedge clk);
    if (rst) begin
      m_inf.delete(); m_q.delete(); ic.delete();
      m_pc = RESET_PC; m_init = 1;
    end else begin
      if (exp_ov && ordy && !byp) void'(m_q.pop_front());
      if (resp) begin
        d = ic.pop_front();
        if (m_inf.size() > 0) begin
          f = m_inf.pop_front();
          if (!f.stale && !redir && !(byp && ordy)) m_q.push_back('{pc: f.pc, instr: d.data});
        end
      end
      if (exp_re && rr) begin
        m_inf.push_back('{pc: m_pc, stale: 0});
        ic.push_back('{data: $urandom(), ready: cyc + $urandom_range(lat_min, lat_max)});
        m_pc = m_pc + PC_STEP;
      end
      if (redir) begin
        m_q.delete();
        foreach (m_inf[i]) m_inf[i].stale = 1;
        m_pc = rpc;
      end
    end
    cyc++;
  endtask

  initial begin
    int first_v, nvalid, acc, k;
    logic [31:0] pcs [4];
    logic [31:0] rpc;

    step(1, 0, '0, 1, 1);
    step(1, 0, '0, 1, 1);

    // Streaming fill: PCs in order, one per cycle after the fill latency.
    first_v = -1; nvalid = 0; k = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, 1, 1);
      if (g_ov) begin
        if (first_v < 0) first_v = i;
        if (k < 4) begin pcs[k] = g_pc; k++; end
        nvalid++;
      end
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    check("first_valid_cycle", first_v, 1);
    check("valid_count", nvalid, 7);
`else
    check("first_valid_cycle", first_v, 2);
    check("valid_count", nvalid, 6);
`endif
    check("stream_pc0", pcs[0], 32'h2000);
    check("stream_pc1", pcs[1], 32'h2004);
    check("stream_pc3", pcs[3], 32'h200C);

    // Decode stalled: exactly DEPTH requests, then drain in order.
    step(1, 0, '0, 1, 0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, '0, 1, 0);
      if (g_re) acc++;
    end
    check("stall_accepts", acc, DEPTH);
    check("stall_re_low", {31'b0, g_re}, 32'h0);
    check("stall_next_addr", g_addr, 32'h2010);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, 1, 1);
      check("drain_pc", g_pc, 32'h2000 + 32'(4 * i));
    end

    // Redirect with requests in flight at latency 3.
    step(1, 0, '0, 1, 1);
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1, 1);
    step(0, 1, 32'h4000, 1, 1);
    step(0, 0, '0, 1, 1);
    check("redir_re", {31'b0, g_re}, 32'h1);
    check("redir_addr", g_addr, 32'h4000);
    first_v = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, '0, 1, 1);
      if (g_ov && first_v == 0) begin
        check("redir_first_pc", g_pc, 32'h4000);
        first_v = 1;
      end
    end
    check("redir_saw_output", first_v, 1);

    // Reset in the middle of operation.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0);
    step(1, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    check("post_reset_valid", {31'b0, g_ov}, 32'h0);
    check("post_reset_addr", g_addr, 32'h2000);

    // Randomized traffic.
    resp_always = 0; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0, rpc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
